// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags
//   Single-clock FIFO with fill level, programmable almost-full/almost-empty
//   flags, optional first-word-fall-through read mode and sticky
//   overflow/underflow error flags. Producer and consumer share clk, so the
//   pointers are plain binary counters with an extra wrap bit.
//
// Ports
//   clk          rising-edge clock for all logic
//   rst          synchronous reset, active-high
//   winc/wdata   write request and data; ignored while wfull
//   wfull        FIFO holds DEPTH words
//   rinc         read request (pops the head in FWFT mode); ignored while rempty
//   rdata        read data (registered; head word in FWFT mode)
//   rempty       no readable word
//   count        words stored, 0..DEPTH
//   almost_full  count >= AFULL_THRESH
//   almost_empty count <= AEMPTY_THRESH
//   overflow     sticky: write attempted while full
//   underflow    sticky: read attempted while empty
module sync_fifo_flags #(
    parameter int DATASIZE      = 8,
    parameter int ADDRSIZE      = 4,
    parameter int AFULL_THRESH  = 2**ADDRSIZE - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                winc,
    input  logic [DATASIZE-1:0] wdata,
    output logic                wfull,
    input  logic                rinc,
    output logic [DATASIZE-1:0] rdata,
    output logic                rempty,
    output logic [ADDRSIZE:0]   count,
    output logic                almost_full,
    output logic                almost_empty,
    output logic                overflow,
    output logic                underflow
);

    localparam int DEPTH = 1 << ADDRSIZE;
    localparam logic [ADDRSIZE:0] AF_TH = (ADDRSIZE+1)'(AFULL_THRESH);
    localparam logic [ADDRSIZE:0] AE_TH = (ADDRSIZE+1)'(AEMPTY_THRESH);

    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH ||
        AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_thresh_check
        $error("sync_fifo_flags: threshold parameter out of legal range");
    end

    logic [DATASIZE-1:0] mem [DEPTH];
    logic [ADDRSIZE:0]   wptr;
    logic [ADDRSIZE:0]   rptr;
    logic [ADDRSIZE:0]   wptr_next;
    logic [ADDRSIZE:0]   rptr_next;
    logic                wr_acc;
    logic                rd_acc;

    // Flags and level come straight from the registered pointers, so they are
    // always mutually consistent and judged on pre-edge values.
    assign rempty       = (wptr == rptr);
    assign wfull        = (wptr[ADDRSIZE] != rptr[ADDRSIZE]) &&
                          (wptr[ADDRSIZE-1:0] == rptr[ADDRSIZE-1:0]);
    assign count        = wptr - rptr;
    assign almost_full  = (count >= AF_TH);
    assign almost_empty = (count <= AE_TH);

    assign wr_acc    = winc && !wfull;
    assign rd_acc    = rinc && !rempty;
    assign wptr_next = wptr + {{ADDRSIZE{1'b0}}, wr_acc};
    assign rptr_next = rptr + {{ADDRSIZE{1'b0}}, rd_acc};

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wptr <= wptr_next;
            rptr <= rptr_next;
            if (winc && wfull)
                overflow <= 1'b1;
            if (rinc && rempty)
                underflow <= 1'b1;
        end
    end

    // Storage is not reset; gating on rst keeps a reset cycle from writing.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc)
            mem[wptr[ADDRSIZE-1:0]] <= wdata;
    end

    if (FWFT != 0) begin : g_fwft
        logic [ADDRSIZE:0] count_next;
        logic              bypass;

        assign count_next = wptr_next - rptr_next;
        // The new head is the word being written this edge exactly when the
        // FIFO will hold only that word; memory does not have it yet.
        assign bypass     = wr_acc && (rptr_next == wptr);

        always_ff @(posedge clk) begin
            if (rst)
                rdata <= '0;
            else if (count_next != '0)
                rdata <= bypass ? wdata : mem[rptr_next[ADDRSIZE-1:0]];
        end
    end else begin : g_std
        always_ff @(posedge clk) begin
            if (rst)
                rdata <= '0;
            else if (rd_acc)
                rdata <= mem[rptr[ADDRSIZE-1:0]];
        end
    end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: a standard-mode and an FWFT-mode instance
// (DEPTH=4) share one stimulus stream. A queue model tracks expected state.
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       winc = 1'b0;
    logic       rinc = 1'b0;
    logic [7:0] wdata = 8'h00;

    logic       wfull_s, rempty_s, af_s, ae_s, ovf_s, unf_s;
    logic [7:0] rdata_s;
    logic [2:0] count_s;
    logic       wfull_f, rempty_f, af_f, ae_f, ovf_f, unf_f;
    logic [7:0] rdata_f;
    logic [2:0] count_f;

    int errors = 0;
    int checks = 0;

    // Reference model
    logic [7:0] mq[$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;
    logic [7:0] m_rd_s = 8'h00;
    logic [7:0] m_rd_f = 8'h00;

    always #5 clk = ~clk;

    sync_fifo_flags #(.DATASIZE(8), .ADDRSIZE(2), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .wfull(wfull_s),
        .rinc(rinc), .rdata(rdata_s), .rempty(rempty_s), .count(count_s),
        .almost_full(af_s), .almost_empty(ae_s), .overflow(ovf_s), .underflow(unf_s)
    );

    sync_fifo_flags #(.DATASIZE(8), .ADDRSIZE(2), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .wfull(wfull_f),
        .rinc(rinc), .rdata(rdata_f), .rempty(rempty_f), .count(count_f),
        .almost_full(af_f), .almost_empty(ae_f), .overflow(ovf_f), .underflow(unf_f)
    );

    task automatic model_update(input logic r_st, input logic w, input logic [7:0] d, input logic r);
        bit full, empty;
        if (r_st) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_rd_s = 8'h00;
            m_rd_f = 8'h00;
        end else begin
            full  = (mq.size() == 4);
            empty = (mq.size() == 0);
            if (w && full)  m_ovf = 1'b1;
            if (r && empty) m_unf = 1'b1;
            if (r && !empty) m_rd_s = mq.pop_front();
            if (w && !full)  mq.push_back(d);
            if (mq.size() > 0) m_rd_f = mq[0];
        end
    endtask

    // Drive one clock of stimulus, then sample 1 ns after the edge.
    task automatic cycle(input logic r_st, input logic w, input logic [7:0] d, input logic r);
        rst = r_st; winc = w; wdata = d; rinc = r;
        @(posedge clk);
        #1;
        model_update(r_st, w, d, r);
        rst = 1'b0; winc = 1'b0; rinc = 1'b0;
    endtask

    task automatic test_reset;
        cycle(1, 0, 8'h00, 0);
        cycle(1, 0, 8'h00, 0);
        checks++; if (rempty_s !== 1'b1) begin errors++; $display("FAIL reset_rempty: got %b want 1", rempty_s); end
        checks++; if (count_s !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count_s); end
        checks++; if (rdata_s !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h want 00", rdata_s); end
        checks++; if ({wfull_s, af_s, ae_s, ovf_s, unf_s} !== 5'b00100) begin errors++; $display("FAIL reset_flags: got %b want 00100", {wfull_s, af_s, ae_s, ovf_s, unf_s}); end
        cycle(0, 0, 8'h00, 1);
        checks++; if (unf_s !== 1'b1) begin errors++; $display("FAIL empty_read_unf: got %b want 1", unf_s); end
        checks++; if ({rempty_s, count_s, rdata_s} !== {1'b1, 3'd0, 8'h00}) begin errors++; $display("FAIL empty_read_state: got %b/%0d/%h want 1/0/00", rempty_s, count_s, rdata_s); end
    endtask

    task automatic test_fill;
        logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        cycle(1, 0, 8'h00, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, vals[i], 0);
            checks++; if (count_s !== 3'(i + 1)) begin errors++; $display("FAIL fill_count%0d: got %0d want %0d", i, count_s, i + 1); end
            checks++; if (af_s !== (i >= 1)) begin errors++; $display("FAIL fill_afull%0d: got %b want %b", i, af_s, (i >= 1)); end
            checks++; if (wfull_s !== (i == 3)) begin errors++; $display("FAIL fill_wfull%0d: got %b want %b", i, wfull_s, (i == 3)); end
        end
        cycle(0, 1, 8'h55, 0);
        checks++; if ({ovf_s, count_s} !== {1'b1, 3'd4}) begin errors++; $display("FAIL fill_overflow: got %b/%0d want 1/4", ovf_s, count_s); end
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 8'h00, 1);
            checks++; if (rdata_s !== vals[i]) begin errors++; $display("FAIL fill_read%0d: got %h want %h", i, rdata_s, vals[i]); end
        end
        checks++; if (rempty_s !== 1'b1) begin errors++; $display("FAIL fill_drained: got %b want 1", rempty_s); end
    endtask

    task automatic test_simultaneous;
        cycle(1, 0, 8'h00, 0);
        for (int i = 1; i <= 4; i++) cycle(0, 1, 8'(i), 0);
        cycle(0, 1, 8'h99, 1);
        checks++; if ({count_s, ovf_s, wfull_s} !== {3'd3, 1'b1, 1'b0}) begin errors++; $display("FAIL simul_full: got %0d/%b/%b want 3/1/0", count_s, ovf_s, wfull_s); end
        checks++; if (rdata_s !== 8'h01) begin errors++; $display("FAIL simul_full_rdata: got %h want 01", rdata_s); end
        for (int i = 0; i < 3; i++) cycle(0, 0, 8'h00, 1);
        checks++; if (rdata_s !== 8'h04) begin errors++; $display("FAIL simul_drain_rdata: got %h want 04", rdata_s); end
        cycle(0, 1, 8'hA5, 1);
        checks++; if ({count_s, unf_s} !== {3'd1, 1'b1}) begin errors++; $display("FAIL simul_empty: got %0d/%b want 1/1", count_s, unf_s); end
        cycle(0, 0, 8'h00, 1);
        checks++; if (rdata_s !== 8'hA5) begin errors++; $display("FAIL simul_empty_read: got %h want a5", rdata_s); end
    endtask

    task automatic test_wrap;
        cycle(1, 0, 8'h00, 0);
        cycle(0, 1, 8'hEE, 0);
        for (int i = 0; i < 20; i++) begin
            cycle(0, 1, 8'(i), 1);
            checks++; if (count_s !== 3'd1) begin errors++; $display("FAIL wrap_count%0d: got %0d want 1", i, count_s); end
            checks++; if (rdata_s !== ((i == 0) ? 8'hEE : 8'(i - 1))) begin errors++; $display("FAIL wrap_rdata%0d: got %h want %h", i, rdata_s, ((i == 0) ? 8'hEE : 8'(i - 1))); end
            checks++; if (rdata_f !== 8'(i)) begin errors++; $display("FAIL wrap_fwft%0d: got %h want %h", i, rdata_f, 8'(i)); end
        end
        checks++; if ({ovf_s, unf_s} !== 2'b00) begin errors++; $display("FAIL wrap_errflags: got %b want 00", {ovf_s, unf_s}); end
    endtask

    task automatic test_fwft;
        cycle(1, 0, 8'h00, 0);
        cycle(0, 1, 8'h3C, 0);
        checks++; if ({rempty_f, rdata_f} !== {1'b0, 8'h3C}) begin errors++; $display("FAIL fwft_show: got %b/%h want 0/3c", rempty_f, rdata_f); end
        cycle(0, 0, 8'h00, 1);
        checks++; if ({rempty_f, rdata_f} !== {1'b1, 8'h3C}) begin errors++; $display("FAIL fwft_pop: got %b/%h want 1/3c", rempty_f, rdata_f); end
    endtask

    task automatic test_reset_mid;
        cycle(1, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 8'h60 + 8'(i), 0);
        cycle(0, 0, 8'h00, 1);
        cycle(0, 1, 8'h63, 0);
        checks++; if (count_s !== 3'd3) begin errors++; $display("FAIL mid_precount: got %0d want 3", count_s); end
        cycle(1, 1, 8'h77, 1);
        checks++; if ({count_s, rempty_s, ovf_s, unf_s} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL mid_reset: got %0d/%b/%b/%b want 0/1/0/0", count_s, rempty_s, ovf_s, unf_s); end
        cycle(0, 0, 8'h00, 0);
        checks++; if ({count_s, rempty_f, rdata_f} !== {3'd0, 1'b1, 8'h00}) begin errors++; $display("FAIL mid_nowrite: got %0d/%b/%h want 0/1/00", count_s, rempty_f, rdata_f); end
    endtask

    task automatic test_random;
        logic [2:0] e_cnt;
        cycle(1, 0, 8'h00, 0);
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 55),
                  8'($urandom), ($urandom_range(0, 99) < 50));
            e_cnt = 3'(mq.size());
            checks++; if ({count_s, count_f} !== {e_cnt, e_cnt}) begin errors++; $display("FAIL rnd_count@%0d: got %0d/%0d want %0d", n, count_s, count_f, e_cnt); end
            checks++; if ({wfull_s, wfull_f, rempty_s, rempty_f} !== {{2{e_cnt == 4}}, {2{e_cnt == 0}}}) begin errors++; $display("FAIL rnd_fullempty@%0d: got %b%b%b%b cnt %0d", n, wfull_s, wfull_f, rempty_s, rempty_f, e_cnt); end
            checks++; if ({af_s, af_f, ae_s, ae_f} !== {{2{e_cnt >= 2}}, {2{e_cnt <= 2}}}) begin errors++; $display("FAIL rnd_almost@%0d: got %b%b%b%b cnt %0d", n, af_s, af_f, ae_s, ae_f, e_cnt); end
            checks++; if ({ovf_s, ovf_f, unf_s, unf_f} !== {m_ovf, m_ovf, m_unf, m_unf}) begin errors++; $display("FAIL rnd_sticky@%0d: got %b%b%b%b want %b%b", n, ovf_s, ovf_f, unf_s, unf_f, m_ovf, m_unf); end
            checks++; if (rdata_s !== m_rd_s) begin errors++; $display("FAIL rnd_rdata_std@%0d: got %h want %h", n, rdata_s, m_rd_s); end
            checks++; if (rdata_f !== m_rd_f) begin errors++; $display("FAIL rnd_rdata_fwft@%0d: got %h want %h", n, rdata_f, m_rd_f); end
        end
    endtask

    initial begin
        test_reset;
        test_fill;
        test_simultaneous;
        test_wrap;
        test_fwft;
        test_reset_mid;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
